// File: rtl/hpm_sampler_pkg.sv
// Shared types and constants for the HPM counter sampler.
// HPM_SAMPLER_TIMESTAMP_EN adds a per-scan timestamp field to each sample.
package hpm_sampler_pkg;

    localparam int          HPM_NUM_CNT       = 6;
    localparam logic [11:0] HPM_CNT_BASE_ADDR = 12'hB03;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2
    } hpm_state_e;

    typedef struct packed {
        logic [2:0]  idx;
        logic [63:0] data;
`ifdef HPM_SAMPLER_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } hpm_sample_t;

endpackage

// File: rtl/hpm_sample_fifo.sv
// First-word fall-through sample buffer; head reads as zero while empty.
module hpm_sample_fifo
    import hpm_sampler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push,
    input  logic        pop,
    input  hpm_sample_t wdata,
    output hpm_sample_t rdata,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    hpm_sample_t   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wdata;
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/hpm_sampler.sv
// Periodic scanner of mhpmcounter3..8 into a sample stream with drop accounting.
// HPM_SAMPLER_TIMESTAMP_EN builds the free-running timestamp counter.
//
// state | meaning
// IDLE  | sampling disabled; timer loads on enable
// WAIT  | timer counting down to the next scan
// SCAN  | reading one selected counter per non-stalled cycle
module hpm_sampler
    import hpm_sampler_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CNT    = HPM_NUM_CNT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic [31:0]        period_i,
    input  logic [NUM_CNT-1:0] cnt_mask_i,
    input  logic               csr_busy_i,
    output logic               pc_req_o,
    output logic [11:0]        pc_addr_o,
    input  logic [63:0]        pc_data_i,
    output logic               smp_valid_o,
    input  logic               smp_ready_i,
    output logic [2:0]         smp_idx_o,
    output logic [63:0]        smp_data_o,
    output logic [31:0]        smp_ts_o,
    output logic               drop_o,
    output logic [7:0]         drop_cnt_o
);
    // {found, index} of the lowest set mask bit at or above start
    function automatic logic [3:0] next_sel(input logic [NUM_CNT-1:0] mask, input int start);
        logic [3:0] r;
        r = '0;
        for (int k = NUM_CNT - 1; k >= 0; k--) begin
            if (mask[k] && (k >= start)) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    hpm_state_e         state;
    logic [31:0]        timer;
    logic [2:0]         idx;
    logic [NUM_CNT-1:0] mask_q;
    logic               en_q;
    logic [31:0]        reload;
    logic [3:0]         first_sel;
    logic [3:0]         scan_sel;
    logic               push, pop, full, empty, drop_event;
    hpm_sample_t        wdata, rdata;

    assign reload     = (period_i == 32'd0) ? 32'd0 : period_i - 32'd1;
    assign first_sel  = next_sel(cnt_mask_i, 0);
    assign scan_sel   = next_sel(mask_q, int'(idx) + 1);

    assign pc_req_o   = enable_i && (state == SCAN) && !csr_busy_i;
    assign pc_addr_o  = pc_req_o ? HPM_CNT_BASE_ADDR + {9'd0, idx} : 12'd0;
    assign pop        = !empty && smp_ready_i;
    assign push       = pc_req_o && (!full || pop);
    assign drop_event = pc_req_o && full && !pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            mask_q     <= '0;
            en_q       <= 1'b0;
            drop_o     <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            en_q <= enable_i;
            if (enable_i && !en_q) begin
                drop_o     <= 1'b0;
                drop_cnt_o <= '0;
            end else if (drop_event) begin
                drop_o <= 1'b1;
                if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
            end

            if (!enable_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        timer <= reload;
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (timer != 32'd0) begin
                            timer <= timer - 32'd1;
                        end else if (first_sel[3]) begin
                            state  <= SCAN;
                            idx    <= first_sel[2:0];
                            mask_q <= cnt_mask_i;
                        end else begin
                            timer <= reload;
                        end
                    end
                    SCAN: begin
                        if (pc_req_o) begin
                            if (scan_sel[3]) begin
                                idx <= scan_sel[2:0];
                            end else begin
                                timer <= reload;
                                state <= WAIT;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef HPM_SAMPLER_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_q;
    logic        first_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_cnt  <= '0;
            ts_q    <= '0;
            first_q <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (state == WAIT && timer == 32'd0 && first_sel[3] && enable_i) first_q <= 1'b1;
            else if (pc_req_o) first_q <= 1'b0;
            if (pc_req_o && first_q) ts_q <= ts_cnt;
        end
    end
`endif

    always_comb begin
        wdata      = '0;
        wdata.idx  = idx;
        wdata.data = pc_data_i;
`ifdef HPM_SAMPLER_TIMESTAMP_EN
        wdata.ts   = first_q ? ts_cnt : ts_q;
`endif
    end

    hpm_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .wdata  (wdata),
        .rdata  (rdata),
        .full   (full),
        .empty  (empty)
    );

    assign smp_valid_o = !empty;
    assign smp_idx_o   = rdata.idx;
    assign smp_data_o  = rdata.data;
`ifdef HPM_SAMPLER_TIMESTAMP_EN
    assign smp_ts_o    = rdata.ts;
`else
    assign smp_ts_o    = 32'd0;
`endif

endmodule

// File: tb/tb_hpm_sampler.sv
// Self-checking bench for hpm_sampler: scan-schedule reference model plus directed scenarios.
module tb_hpm_sampler;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] period = 32'd0;
    logic [5:0]  mask = 6'd0;
    logic        busy = 1'b0;
    logic        ready = 1'b0;
    logic [63:0] pc_data = 64'd0;
    logic        pc_req;
    logic [11:0] pc_addr;
    logic        smp_valid;
    logic [2:0]  smp_idx;
    logic [63:0] smp_data;
    logic [31:0] smp_ts;
    logic        drop;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hpm_sampler #(.FIFO_DEPTH(DEPTH), .NUM_CNT(6)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .enable_i    (enable),
        .period_i    (period),
        .cnt_mask_i  (mask),
        .csr_busy_i  (busy),
        .pc_req_o    (pc_req),
        .pc_addr_o   (pc_addr),
        .pc_data_i   (pc_data),
        .smp_valid_o (smp_valid),
        .smp_ready_i (ready),
        .smp_idx_o   (smp_idx),
        .smp_data_o  (smp_data),
        .smp_ts_o    (smp_ts),
        .drop_o      (drop),
        .drop_cnt_o  (drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of counters still to read this scan, a
    // countdown of idle cycles until the next scan, and a sample queue.
    typedef struct {
        int          idx;
        logic [63:0] data;
        logic [31:0] ts;
    } samp_t;

    samp_t       fq[$];
    int          scan_q[$];
    bit          m_on, prev_en, m_first, was_scanning, exp_req, do_pop;
    int          countdown, m_drops, eff_period;
    logic [31:0] tsc, ts_scan;
    samp_t       s;
    int          cycle = 0;
    int          req_cyc[$];
    logic [11:0] req_addr[$];

    always @(negedge clk) begin
        if (!rst_ni) begin
            fq.delete(); scan_q.delete();
            m_on = 0; prev_en = 0; m_first = 0; countdown = 0; m_drops = 0;
            tsc = 0; ts_scan = 0;
            check("rst_pc_req", pc_req, 0);
            check("rst_pc_addr", pc_addr, 0);
            check("rst_valid", smp_valid, 0);
            check("rst_drop", drop, 0);
            check("rst_drop_cnt", drop_cnt, 0);
            check("rst_ts", smp_ts, 0);
        end else begin
            eff_period = (period == 0) ? 1 : int'(period);
            was_scanning = scan_q.size() > 0;
            exp_req = m_on && was_scanning && enable && !busy;
            check("pc_req", pc_req, exp_req);
            check("pc_addr", pc_addr, exp_req ? 64'(12'hB03 + scan_q[0]) : 64'd0);
            check("smp_valid", smp_valid, fq.size() > 0);
            if (fq.size() > 0) begin
                check("smp_idx", smp_idx, fq[0].idx);
                check("smp_data", smp_data, fq[0].data);
`ifdef HPM_SAMPLER_TIMESTAMP_EN
                check("smp_ts", smp_ts, fq[0].ts);
`endif
            end
`ifndef HPM_SAMPLER_TIMESTAMP_EN
            check("smp_ts_zero", smp_ts, 0);
`endif
            check("drop", drop, m_drops > 0);
            check("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
            if (exp_req) begin
                req_cyc.push_back(cycle);
                req_addr.push_back(pc_addr);
            end

            do_pop = fq.size() > 0 && ready;
            if (do_pop) void'(fq.pop_front());
            if (exp_req) begin
                s.idx  = scan_q.pop_front();
                s.data = pc_data;
                s.ts   = m_first ? tsc : ts_scan;
                if (m_first) ts_scan = tsc;
                m_first = 0;
                if (fq.size() < DEPTH) fq.push_back(s);
                else m_drops++;
                if (scan_q.size() == 0) countdown = eff_period;
            end
            if (enable && !prev_en) m_drops = 0;
            if (!enable) begin
                m_on = 0;
                scan_q.delete();
            end else if (!m_on) begin
                m_on = 1;
                countdown = eff_period;
            end else if (!was_scanning) begin
                countdown--;
                if (countdown == 0) begin
                    for (int k = 0; k < 6; k++) if (mask[k]) scan_q.push_back(k);
                    if (scan_q.size() == 0) countdown = eff_period;
                    else m_first = 1;
                end
            end
            prev_en = enable;
        end
        tsc++;
        cycle++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 pc_data = {$urandom, $urandom};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int reqs_since(input int c);
        int n = 0;
        foreach (req_cyc[i]) if (req_cyc[i] >= c) n++;
        return n;
    endfunction

    function automatic int first_req_since(input int c);
        foreach (req_cyc[i]) if (req_cyc[i] >= c) return i;
        return -1;
    endfunction

    int c0, i0;
    bit gaps_ok;

    initial begin
        step(3);
        rst_ni = 1'b1;

        // Two counters, period 10: reads at B03/B05 back to back every 12 cycles
        period = 10; mask = 6'b000101; ready = 1; enable = 1; c0 = cycle;
        step(40);
        i0 = first_req_since(c0);
        check("t035_latency", req_cyc[i0] - c0, 11);
        check("t035_addr0", req_addr[i0], 12'hB03);
        check("t035_addr1", req_addr[i0+1], 12'hB05);
        check("t035_gap", req_cyc[i0+1] - req_cyc[i0], 1);
        check("t035_period", req_cyc[i0+2] - req_cyc[i0], 12);

        // Stall 3 cycles at idx 2
        enable = 0; step(2);
        enable = 1; c0 = cycle;
        step(12); busy = 1; step(3); busy = 0; step(3);
        i0 = first_req_since(c0);
        check("t036_first", req_cyc[i0] - c0, 11);
        check("t036_stalled_read", req_cyc[i0+1] - c0, 15);
        check("t036_addr", req_addr[i0+1], 12'hB05);
        check("t036_count", reqs_since(c0), 2);

        // Overflow: 4 held, 2 dropped, then saturation
        enable = 0; ready = 1; step(10);
        ready = 0; step(1);
        mask = 6'h3F; enable = 1;
        step(19);
        check("t037_valid", smp_valid, 1);
        check("t037_drop", drop, 1);
        check("t037_drop_cnt", drop_cnt, 2);
        period = 1; step(400);
        check("t037_saturate", drop_cnt, 255);

        // Disable mid-scan after idx 1
        enable = 0; ready = 1; step(10);
        ready = 0; period = 10; step(1);
        enable = 1; c0 = cycle;
        step(13); enable = 0; step(10);
        check("t038_reqs", reqs_since(c0), 2);
        check("t038_held", smp_valid, 1);
        ready = 1; step(3);
        check("t038_drained", smp_valid, 0);

        // Period 0, empty mask, then single counter every 2 cycles
        period = 0; mask = 6'h00; enable = 1; c0 = cycle;
        step(30);
        check("t039_none", reqs_since(c0), 0);
        mask = 6'h01; c0 = cycle;
        step(20);
        i0 = first_req_since(c0);
        gaps_ok = (reqs_since(c0) >= 8);
        for (int i = i0 + 1; i < req_cyc.size(); i++)
            if (req_cyc[i] - req_cyc[i-1] != 2 || req_addr[i] != 12'hB03) gaps_ok = 0;
        check("t039_every2", gaps_ok, 1);

        // Async reset mid-scan with a full FIFO
        enable = 0; step(2);
        ready = 0; mask = 6'h3F; period = 4; enable = 1;
        step(9);
        check("t040_full_pre", smp_valid, 1);
        #2 rst_ni = 0;
        #1;
        check("t040_async_req", pc_req, 0);
        check("t040_async_addr", pc_addr, 0);
        check("t040_async_valid", smp_valid, 0);
        check("t040_async_drop", drop_cnt, 0);
        check("t040_async_ts", smp_ts, 0);
        step(2);
        rst_ni = 1; ready = 1; c0 = cycle;
        step(8);
        i0 = first_req_since(c0);
        check("t040_first_scan", req_cyc[i0] - c0, 5);
        check("t040_first_addr", req_addr[i0], 12'hB03);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 2)  enable = ~enable;
            if ($urandom_range(0, 99) < 5)  mask = 6'($urandom);
            if ($urandom_range(0, 99) < 3)  period = 32'($urandom_range(0, 5));
            busy  = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 1) == 1);
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
